// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUFUN codes, CNVZ flag bit positions and the tagged result record.
package alu_pkg;

   localparam int ALU_WIDTH = 4;

   typedef enum logic [3:0] {
      SLR = 4'd0,
      SLL = 4'd1,
      SAR = 4'd2,
      SAL = 4'd3,
      OR  = 4'd4,
      AND = 4'd5,
      XOR = 4'd6,
      NOT = 4'd7,
      ADD = 4'd8,
      SUB = 4'd9
   } alu_fun_e;

   localparam int FLAG_C = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_Z = 0;

   typedef struct packed {
      alu_fun_e               fun;
      logic [3:0]             cnvz;
      logic [ALU_WIDTH-1:0]   s;
   } alu_res_t;

endpackage

// File: rtl/alu_fifo_ram.sv
// DEPTH x ENTRY_W register array: one synchronous write port, one combinational read port.
module alu_fifo_ram #(
   parameter  int ENTRY_W = 12,
   parameter  int DEPTH   = 4,
   localparam int ADDR_W  = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               we,
   input  logic [ADDR_W-1:0]  waddr,
   input  logic [ENTRY_W-1:0] wdata,
   input  logic [ADDR_W-1:0]  raddr,
   output logic [ENTRY_W-1:0] rdata
);

   logic [ENTRY_W-1:0] mem [DEPTH];

   // NOTE: storage is reset so the head outputs read as zero during and right after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/alu_result_fifo.sv
// Tagged ALU result FIFO with valid/ready on both sides and first-word-fall-through head.
// Optional sticky CNVZ accumulator enabled by defining ALU_RESULT_STICKY_EN.
module alu_result_fifo
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         alu_s,
   input  logic [3:0]               alu_cnvz,
   input  logic [3:0]               alu_fun,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_s,
   output logic [3:0]               out_cnvz,
   output logic [3:0]               out_fun,
   output logic [$clog2(DEPTH):0]   count,
   output logic [3:0]               sticky,
   input  logic                     clr_sticky
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int ENTRY_W = WIDTH + 8;

   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count_q;
   logic [ENTRY_W-1:0] head;
   logic               push;
   logic               pop;

   // Full/empty derive from occupancy alone, so pointers may wrap freely.
   assign in_ready  = (count_q != CNT_W'(DEPTH));
   assign out_valid = (count_q != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign count     = count_q;

   alu_fifo_ram #(
      .ENTRY_W (ENTRY_W),
      .DEPTH   (DEPTH)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (push),
      .waddr (wr_ptr),
      .wdata ({alu_fun, alu_cnvz, alu_s}),
      .raddr (rd_ptr),
      .rdata (head)
   );

   assign {out_fun, out_cnvz, out_s} = head;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

`ifdef ALU_RESULT_STICKY_EN
   logic [3:0] sticky_q;

   // Clear wins over accumulation, so a same-cycle push restarts from its own flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_q <= '0;
      end else if (clr_sticky) begin
         sticky_q <= push ? alu_cnvz : 4'b0;
      end else if (push) begin
         sticky_q <= sticky_q | alu_cnvz;
      end
   end

   assign sticky = sticky_q;
`else
   logic unused_clr_sticky;

   assign unused_clr_sticky = clr_sticky;
   assign sticky            = 4'b0;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Randomised self-checking bench for alu_result_fifo against a queue-based reference model.
// Build with or without ALU_RESULT_STICKY_EN; the sticky expectations follow the macro.
module tb_alu_result_fifo;
   import alu_pkg::*;

   localparam int DEPTH = 4;

   typedef struct {
      logic [3:0] fun;
      logic [3:0] cnvz;
      logic [3:0] s;
   } ent_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] alu_s;
   logic [3:0] alu_cnvz;
   logic [3:0] alu_fun;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_s;
   logic [3:0] out_cnvz;
   logic [3:0] out_fun;
   logic [2:0] count;
   logic [3:0] sticky;
   logic       clr_sticky;

   int   checks = 0;
   int   errors = 0;
   ent_t q[$];
   logic [3:0] sticky_m = 4'b0;

   alu_result_fifo #(.WIDTH(4), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .alu_s      (alu_s),
      .alu_cnvz   (alu_cnvz),
      .alu_fun    (alu_fun),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_s      (out_s),
      .out_cnvz   (out_cnvz),
      .out_fun    (out_fun),
      .count      (count),
      .sticky     (sticky),
      .clr_sticky (clr_sticky)
   );

   always #5 clk = ~clk;

   // One clock of stimulus, starting and ending just after a falling edge.
   task automatic drive_cycle(input logic v, input logic [3:0] s, input logic [3:0] cnvz,
                              input logic [3:0] fun, input logic rdy, input logic clr);
      logic exp_push;
      logic exp_pop;
      in_valid   = v;
      alu_s      = s;
      alu_cnvz   = cnvz;
      alu_fun    = fun;
      out_ready  = rdy;
      clr_sticky = clr;
      #1;
      exp_push = v && (q.size() < DEPTH);
      exp_pop  = rdy && (q.size() > 0);
      checks++;
      if (out_valid !== (q.size() > 0)) begin
         errors++;
         $display("FAIL out_valid: got %b expected %b", out_valid, q.size() > 0);
      end
      checks++;
      if (count !== 3'(q.size())) begin
         errors++;
         $display("FAIL count: got %0d expected %0d", count, q.size());
      end
      checks++;
      if (in_ready !== (q.size() < DEPTH)) begin
         errors++;
         $display("FAIL in_ready: got %b expected %b", in_ready, q.size() < DEPTH);
      end
      if (q.size() > 0) begin
         checks++;
         if ({out_fun, out_cnvz, out_s} !== {q[0].fun, q[0].cnvz, q[0].s}) begin
            errors++;
            $display("FAIL head: got fun=%h cnvz=%b s=%h expected fun=%h cnvz=%b s=%h",
                     out_fun, out_cnvz, out_s, q[0].fun, q[0].cnvz, q[0].s);
         end
      end
      checks++;
      if (sticky !== sticky_m) begin
         errors++;
         $display("FAIL sticky: got %b expected %b", sticky, sticky_m);
      end
      @(posedge clk);
      if (exp_pop) void'(q.pop_front());
      if (exp_push) q.push_back('{fun: fun, cnvz: cnvz, s: s});
`ifdef ALU_RESULT_STICKY_EN
      if (clr) sticky_m = exp_push ? cnvz : 4'b0;
      else if (exp_push) sticky_m = sticky_m | cnvz;
`endif
      @(negedge clk);
   endtask

   task automatic idle_cycle();
      drive_cycle(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
   endtask

   task automatic drain();
      while (q.size() > 0) drive_cycle(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
      idle_cycle();
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      clr_sticky = 1'b0;
      alu_s      = '0;
      alu_cnvz   = '0;
      alu_fun    = '0;
      #3;
      checks++;
      if ({out_valid, in_ready, count, out_s, out_cnvz, out_fun, sticky} !== {1'b0, 1'b1, 3'd0, 16'h0}) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b ready=%b count=%0d s=%h cnvz=%b fun=%h sticky=%b expected 0 1 0 0 0 0 0",
                  out_valid, in_ready, count, out_s, out_cnvz, out_fun, sticky);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle_cycle();
   endtask

   task automatic test_first_push();
      drive_cycle(1'b1, 4'h1, 4'b0000, ADD, 1'b0, 1'b0);
      #1;
      checks++;
      if ({out_valid, out_s, out_fun, count} !== {1'b1, 4'h1, 4'd8, 3'd1}) begin
         errors++;
         $display("FAIL first_push: got valid=%b s=%h fun=%0d count=%0d expected 1 1 8 1",
                  out_valid, out_s, out_fun, count);
      end
      drain();
   endtask

   task automatic test_fill_drain();
      for (int i = 1; i <= 5; i++) drive_cycle(1'b1, 4'(i), 4'(i), SUB, 1'b0, 1'b0);
      #1;
      checks++;
      if ({count, in_ready, out_s} !== {3'd4, 1'b0, 4'h1}) begin
         errors++;
         $display("FAIL fill: got count=%0d ready=%b head=%h expected 4 0 1", count, in_ready, out_s);
      end
      for (int i = 1; i <= 4; i++) begin
         checks++;
         if (out_s !== 4'(i)) begin
            errors++;
            $display("FAIL drain_order: got %h expected %h", out_s, 4'(i));
         end
         drive_cycle(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
      end
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL drain_empty: got out_valid=%b expected 0", out_valid);
      end
      idle_cycle();
   endtask

   task automatic test_full_push_pop();
      for (int i = 0; i < 4; i++) drive_cycle(1'b1, 4'(i + 10), 4'h3, XOR, 1'b0, 1'b0);
      drive_cycle(1'b1, 4'h9, 4'h6, AND, 1'b1, 1'b0);
      #1;
      checks++;
      if (count !== 3'd3) begin
         errors++;
         $display("FAIL full_pop_count: got %0d expected 3", count);
      end
      drive_cycle(1'b1, 4'h9, 4'h6, AND, 1'b0, 1'b0);
      #1;
      checks++;
      if (count !== 3'd4) begin
         errors++;
         $display("FAIL full_retry_count: got %0d expected 4", count);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      drive_cycle(1'b1, 4'hA, 4'h1, OR, 1'b0, 1'b0);
      drive_cycle(1'b1, 4'hB, 4'h2, OR, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++)
         drive_cycle(1'b1, 4'($urandom), 4'($urandom), 4'($urandom_range(9)), 1'b1, 1'b0);
      #1;
      checks++;
      if (count !== 3'd2) begin
         errors++;
         $display("FAIL back_to_back_count: got %0d expected 2", count);
      end
      drain();
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) drive_cycle(1'b1, 4'(i + 5), 4'hF, SAL, 1'b0, 1'b0);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, count, in_ready, out_s, sticky} !== {1'b0, 3'd0, 1'b1, 4'h0, 4'h0}) begin
         errors++;
         $display("FAIL async_reset: got valid=%b count=%0d ready=%b s=%h sticky=%b expected 0 0 1 0 0",
                  out_valid, count, in_ready, out_s, sticky);
      end
      q.delete();
      sticky_m = 4'b0;
      @(negedge clk);
      rst_n = 1'b1;
      idle_cycle();
   endtask

   task automatic test_sticky();
      logic [3:0] exp_a;
      logic [3:0] exp_b;
`ifdef ALU_RESULT_STICKY_EN
      exp_a = 4'b1001;
      exp_b = 4'b0100;
`else
      exp_a = 4'b0000;
      exp_b = 4'b0000;
`endif
      drive_cycle(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
      drive_cycle(1'b1, 4'h1, 4'b1000, ADD, 1'b0, 1'b0);
      drive_cycle(1'b1, 4'h2, 4'b0001, SUB, 1'b0, 1'b0);
      #1;
      checks++;
      if (sticky !== exp_a) begin
         errors++;
         $display("FAIL sticky_accum: got %b expected %b", sticky, exp_a);
      end
      drive_cycle(1'b1, 4'h3, 4'b0100, NOT, 1'b0, 1'b1);
      #1;
      checks++;
      if (sticky !== exp_b) begin
         errors++;
         $display("FAIL sticky_clear_push: got %b expected %b", sticky, exp_b);
      end
      drain();
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++)
         drive_cycle(1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom_range(9)),
                     1'($urandom), ($urandom_range(15) == 0));
      drain();
   endtask

   initial begin
      test_reset();
      test_first_push();
      test_fill_drain();
      test_full_push_pop();
      test_back_to_back();
      test_async_reset();
      test_sticky();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
